// File: rtl/sel2pal_pkg.sv
// -----------------------------------------------------------------------------
// sel2pal_pkg
// Shared definitions for the sel2pal serial write link scheduler:
//   - state_e    : scheduler FSM states (IDLE, SHIFT, GAP)
//   - FRAME_BITS : default frame width; must match the slow-domain receiver
//   - onehot()   : index -> one-hot vector helper (up to MAX_REQ requesters)
// -----------------------------------------------------------------------------
package sel2pal_pkg;

    localparam int FRAME_BITS = 8;
    localparam int MAX_REQ    = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
        return {{(MAX_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/sel2pal_tx_sched_if.sv
// -----------------------------------------------------------------------------
// sel2pal_tx_sched_if
// Bundle between the byte requesters and the serial link scheduler.
//   req       : per-requester request, held with data stable until gnt
//   req_data  : byte i in bits [i*DATA_W +: DATA_W]
//   gnt       : one-hot, one-cycle pulse when a byte is accepted
//   ser_wr_n  : active-low write strobe towards the slow-domain receiver
//   ser_dout  : serial data, MSB first, valid while ser_wr_n = 0
//   busy      : scheduler is shifting or holding the idle gap
//   last_id   : index of the most recently granted requester
//   frame_cnt : frames sent (only when SEL2PAL_FRAME_CNT_EN is defined)
// Modports: master = requester side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface sel2pal_tx_sched_if
    import sel2pal_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = FRAME_BITS
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        gnt;
    logic                    ser_wr_n;
    logic                    ser_dout;
    logic                    busy;
    logic [ID_W-1:0]         last_id;
`ifdef SEL2PAL_FRAME_CNT_EN
    logic [15:0]             frame_cnt;

    modport master (output req, req_data,
                    input  gnt, ser_wr_n, ser_dout, busy, last_id, frame_cnt);
    modport slave  (input  req, req_data,
                    output gnt, ser_wr_n, ser_dout, busy, last_id, frame_cnt);
`else
    modport master (output req, req_data,
                    input  gnt, ser_wr_n, ser_dout, busy, last_id);
    modport slave  (input  req, req_data,
                    output gnt, ser_wr_n, ser_dout, busy, last_id);
`endif

endinterface

// File: rtl/sel2pal_rr_arb.sv
// -----------------------------------------------------------------------------
// sel2pal_rr_arb
// Combinational round-robin arbiter. Searches req_i for the first set bit
// starting at last_id_i+1 and wrapping, so the last winner has lowest priority.
//   req_i     : request vector
//   last_id_i : index of the previous winner
//   any_o     : at least one request present
//   id_o      : index of the winner (0 when any_o = 0)
//   onehot_o  : one-hot of the winner (all zero when any_o = 0)
// -----------------------------------------------------------------------------
module sel2pal_rr_arb
    import sel2pal_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  last_id_i,
    output logic             any_o,
    output logic [ID_W-1:0]  id_o,
    output logic [N_REQ-1:0] onehot_o
);

    int idx;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        any_o = 1'b0;
        id_o  = '0;
        idx   = 0;
        // Walk from the farthest offset to the nearest; the last hit wins, which
        // is the requester closest after last_id_i.
        for (int off = N_REQ; off >= 1; off--) begin
            idx = (int'(last_id_i) + off) % N_REQ;
            if (req_i[idx]) begin
                any_o = 1'b1;
                id_o  = ID_W'(idx);
            end
        end
        onehot_o = any_o ? N_REQ'(onehot(int'(id_o))) : '0;
    end

endmodule

// File: rtl/sel2pal_tx_sched.sv
// -----------------------------------------------------------------------------
// sel2pal_tx_sched
// Fast-domain scheduler for the serial write link into the fast-to-slow
// serial-to-parallel receiver. Arbitrates N_REQ byte requesters round-robin,
// shifts the granted byte out MSB first under an active-low strobe, then holds
// GAP_CYC idle cycles so the slow-domain synchroniser sees every strobe rise.
// Ports:
//   clk : fast clock, all logic on posedge
//   rst : asynchronous active-high reset
//   bus : sel2pal_tx_sched_if.slave (req/req_data in; gnt, ser_wr_n,
//         ser_dout, busy, last_id, [frame_cnt] out; all outputs registered)
// Optional feature: define SEL2PAL_FRAME_CNT_EN to add the 16-bit frame_cnt
// output, incremented on every SHIFT->GAP transition.
// -----------------------------------------------------------------------------
module sel2pal_tx_sched
    import sel2pal_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = FRAME_BITS,
    parameter int GAP_CYC = 8
) (
    input  logic               clk,
    input  logic               rst,
    sel2pal_tx_sched_if.slave  bus
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int BIT_W = (DATA_W  > 1) ? $clog2(DATA_W)  : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYC - 1);

    state_e              state_q, state_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic                ser_wr_n_q, ser_wr_n_d;
    logic                ser_dout_q, ser_dout_d;
    logic                busy_q, busy_d;
    logic [ID_W-1:0]     last_id_q, last_id_d;
    logic [DATA_W-1:0]   sreg_q, sreg_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
`ifdef SEL2PAL_FRAME_CNT_EN
    logic [15:0]         frame_cnt_q, frame_cnt_d;
`endif

    logic                arb_any;
    logic [ID_W-1:0]     arb_id;
    logic [N_REQ-1:0]    arb_onehot;
    logic [DATA_W-1:0]   sel_data;
    logic                gap_last;
    logic                start;

    sel2pal_rr_arb #(.N_REQ(N_REQ)) u_arb (
        .req_i     (bus.req),
        .last_id_i (last_id_q),
        .any_o     (arb_any),
        .id_o      (arb_id),
        .onehot_o  (arb_onehot)
    );

    assign sel_data = bus.req_data[arb_id*DATA_W +: DATA_W];
    assign gap_last = (state_q == GAP) && (gap_cnt_q == LAST_GAP);
    // The last gap cycle doubles as the IDLE arbitration slot, so back-to-back
    // frames are exactly DATA_W + GAP_CYC cycles apart.
    assign start    = arb_any && ((state_q == IDLE) || gap_last);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (arb_any) state_d = SHIFT;
            SHIFT:   if (bit_cnt_q == LAST_BIT) state_d = GAP;
            GAP:     if (gap_last) state_d = arb_any ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        gnt_d      = '0;
        ser_wr_n_d = ser_wr_n_q;
        ser_dout_d = ser_dout_q;
        busy_d     = busy_q;
        last_id_d  = last_id_q;
        sreg_d     = sreg_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
`ifdef SEL2PAL_FRAME_CNT_EN
        frame_cnt_d = frame_cnt_q;
`endif
        if (start) begin
            gnt_d      = arb_onehot;
            sreg_d     = sel_data;
            ser_wr_n_d = 1'b0;
            ser_dout_d = sel_data[DATA_W-1];
            last_id_d  = arb_id;
            busy_d     = 1'b1;
            bit_cnt_d  = '0;
        end else begin
            unique case (state_q)
                SHIFT: begin
                    if (bit_cnt_q == LAST_BIT) begin
                        ser_wr_n_d = 1'b1;
                        ser_dout_d = 1'b0;
                        gap_cnt_d  = '0;
`ifdef SEL2PAL_FRAME_CNT_EN
                        frame_cnt_d = frame_cnt_q + 16'd1;
`endif
                    end else begin
                        // sreg_q[DATA_W-1] is already on the wire; the next bit sits below it.
                        ser_dout_d = sreg_q[DATA_W-2];
                        sreg_d     = sreg_q << 1;
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == LAST_GAP) begin
                        busy_d = 1'b0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers; reset drops the strobe immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q      <= '0;
            ser_wr_n_q <= 1'b1;
            ser_dout_q <= 1'b0;
            busy_q     <= 1'b0;
            last_id_q  <= ID_W'(N_REQ - 1);
            sreg_q     <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
`ifdef SEL2PAL_FRAME_CNT_EN
            frame_cnt_q <= '0;
`endif
        end else begin
            gnt_q      <= gnt_d;
            ser_wr_n_q <= ser_wr_n_d;
            ser_dout_q <= ser_dout_d;
            busy_q     <= busy_d;
            last_id_q  <= last_id_d;
            sreg_q     <= sreg_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
`ifdef SEL2PAL_FRAME_CNT_EN
            frame_cnt_q <= frame_cnt_d;
`endif
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.ser_wr_n = ser_wr_n_q;
    assign bus.ser_dout = ser_dout_q;
    assign bus.busy     = busy_q;
    assign bus.last_id  = last_id_q;
`ifdef SEL2PAL_FRAME_CNT_EN
    assign bus.frame_cnt = frame_cnt_q;
`endif

endmodule
